// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the edge-detection master and the SRAM responder.
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder wrapping a word-addressed SRAM with programmable wait
// states and saturating transfer counters.
// Optional build macro AHB_SRAM_ERR_EN: range/alignment check with a
// two-cycle ERROR response; when undefined, addresses alias and hresp is 0.
module ahb_sram_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              n_rst,
  ahb_sram_slave_if.slave   bus,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
`endif

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                valid_q;

  logic [31:0]         hrdata_q;
  logic [31:0]         mem [2**ADDR_W];

  logic [31:0]         offset;
  logic [ADDR_W-1:0]   acc_idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic                bad;
  logic                ready_c;
  logic                take;
  logic                next_wr;
  logic                load_rd;
  logic                wr_end;
  logic                rd_end;

  assign offset  = bus.haddr - BASE_ADDR;
  assign acc_idx = offset[ADDR_W+1:2];

`ifdef AHB_SRAM_ERR_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));
  logic resp_c;
  assign bad = (bus.haddr < BASE_ADDR) || ({1'b0, bus.haddr} >= LIMIT) ||
               (bus.haddr[1:0] != 2'b00);
  assign bus.hresp = resp_c;
`else
  assign bad       = 1'b0;
  assign bus.hresp = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{offset[31:ADDR_W+2], offset[1:0], bus.haddr[1:0], bus.htrans[0]};

  // Next-state, wait countdown, hready/hresp and address-phase accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_c = 1'b1;
`ifdef AHB_SRAM_ERR_EN
    resp_c  = 1'b0;
`endif
    case (state_q)
      IDLE: ;
      WAIT: begin
        ready_c = 1'b0;
        if (cnt_q == 4'd1) state_d = DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DATA: state_d = IDLE;
`ifdef AHB_SRAM_ERR_EN
      ERR1: begin
        ready_c = 1'b0;
        resp_c  = 1'b1;
        state_d = ERR2;
      end
      ERR2: begin
        resp_c  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    take = ready_c && bus.hsel && bus.htrans[1];
    if (take) begin
      if (bad) begin
`ifdef AHB_SRAM_ERR_EN
        state_d = ERR1;
`endif
      end else if (WAIT_STATES == 0) begin
        state_d = DATA;
      end else begin
        state_d = WAIT;
        cnt_d   = WS;
      end
    end
  end

  // Entering DATA from WAIT serves the registered transfer; entering it
  // straight from an accept (zero wait states) serves the live address.
  assign next_wr = (state_q == WAIT) ? write_q : bus.hwrite;
  assign load_rd = (state_d == DATA) && !next_wr;
  assign rd_idx  = (state_q == WAIT) ? addr_q : acc_idx;
  assign wr_end  = (state_q == DATA) && valid_q && write_q;
  assign rd_end  = (state_q == DATA) && valid_q && !write_q;

  // State, wait counter and captured address-phase controls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        addr_q  <= acc_idx;
        write_q <= bus.hwrite;
        valid_q <= !bad;
      end
    end
  end

  // SRAM write at the edge ending a write data phase.
  always_ff @(posedge clk) begin
    if (n_rst && wr_end) mem[addr_q] <= bus.hwdata;
  end

  // Registered read data, with write-to-read forwarding on the same word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      hrdata_q <= '0;
    else if (load_rd)
      hrdata_q <= (wr_end && (rd_idx == addr_q)) ? bus.hwdata : mem[rd_idx];
  end

  assign bus.hrdata = hrdata_q;
  assign bus.hready = ready_c;

  // Saturating completion counters.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_end && (rd_count != '1)) rd_count <= rd_count + 16'd1;
      if (wr_end && (wr_count != '1)) wr_count <= wr_count + 16'd1;
    end
  end

endmodule
